pixel_pack_writer: RTL and testbench
====================================

# pixel_pack_writer

Write-side counterpart of the packed 4-bit sprite/frame memory: accepts a stream of 4-bit pixels addressed by 20-bit pixel address, packs them four-per-word into 16-bit words (pixel n in bits [4n+3:4n], n = addr[1:0]), and issues nibble-masked word writes to the memory write port. Sits between the drawing engine (sprite blitter) and the frame-buffer memory. Supports a transparent colour key, so sprite pixels matching the key never overwrite the background.

## Interface
- TRANSP_EN, 1: enable transparent-key suppression
- TRANSP_KEY, 4'h0: pixel value treated as transparent when TRANSP_EN=1
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- pix_valid  in  1  pixel offered
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- pix_addr  in  20  pixel address; word = [19:2], nibble = [1:0]
- pix_data  in  4  pixel colour index
- pix_last  in  1  flush the open word after this pixel
- wr_valid  out  1  write request
- wr_ready  in  1  memory accepts write when wr_valid && wr_ready
- wr_addr  out  18  word address
- wr_data  out  16  packed word
- wr_mask  out  4  per-nibble write enable; bit n enables bits [4n+3:4n]
- busy  out  1  open word, pending write or held pixel exists

## Operation
- States: EMPTY, OPEN, FLUSH. Accumulator: acc_addr[17:0], acc_data[15:0], acc_mask[3:0]. Hold register: one pixel (addr, data, last) plus hold_v.
- Merge of pixel p into accumulator: acc_data nibble p.addr[1:0] <= p.data; mask bit set unless TRANSP_EN && p.data==TRANSP_KEY (bit left unchanged). Repeated nibble in same word: later pixel overwrites data; mask bit ORs.
- EMPTY: pix_ready=1. Accept -> load acc_addr=pix_addr[19:2], clear data/mask, merge. Go FLUSH if pix_addr[1:0]==3 or pix_last, else OPEN.
- OPEN: pix_ready=1. Accept, same word -> merge; FLUSH if nibble 3 or pix_last, else stay. Accept, different word -> capture pixel in hold, go FLUSH.
- FLUSH: pix_ready=0. If acc_mask==0: no write, wr_valid stays 0, exit next cycle. Else wr_valid=1 until wr_ready. On exit: hold_v -> load hold pixel into fresh accumulator (same rules as EMPTY accept, so nibble 3/last goes straight back to FLUSH), clear hold_v; else EMPTY.
- busy = (state != EMPTY) || hold_v.
- Reset mid-operation discards open word and held pixel; no write issued.

## Timing
- Reset values: pix_ready=1, wr_valid=0, wr_addr=0, wr_data=0, wr_mask=0, busy=0, state EMPTY, hold_v=0.
- wr_* registered: wr_valid rises the cycle after the flush-triggering pixel is accepted (or after the completing write handshake when reloading from hold).
- wr_addr/wr_data/wr_mask stable while wr_valid && !wr_ready.
- Full contiguous word: 4 accept cycles + 1 write cycle (wr_ready held high) = 5 cycles/word; pix_ready low exactly 1 cycle.
- Fully transparent word: FLUSH lasts 1 cycle, no wr_valid.
- wr_ready low: pix_ready stays 0; no pixel lost, no write duplicated.
- pix_ready depends only on state (no combinational path from pix_* or wr_ready).

## Structure
- Shared package boxhead_mem_pkg: PIX_ADDR_W=20, WORD_ADDR_W=18, PIX_W=4, WORD_W=16, PIX_PER_WORD=4, state enum typedef, pixel struct {addr, data, last}.
- One sub-module: nibble_merge (combinational: data, mask, nibble index, pixel, transparency params -> new data, new mask), used for both accept and hold-reload paths.

## Test plan
- Pixels addr 0x00010..0x00013 data 1,2,3,4, wr_ready=1 -> one write wr_addr=0x00004, wr_data=0x4321, wr_mask=4'hF; pix_ready low one cycle.
- TRANSP_EN=1, key 0: pixels 0x00020 data 5, 0x00021 data 0, 0x00022 data 7 last -> wr_addr=0x00008, wr_data=0x0705, wr_mask=4'b0101.
- Pixel 0x00001 data A, then 0x00009 data B last, wr_ready=1 -> write addr 0, data 0x00A0, mask 0010; then addr 2, data 0x00B0, mask 0010; no pixel dropped.
- All four pixels of word 0x00005 = key, last on nibble 3 -> no wr_valid pulse, returns to EMPTY, busy falls.
- wr_ready held low 10 cycles during write of 0x00004 -> wr_* constant, pix_ready=0 throughout, single handshake when released.
- Reset asserted while OPEN with 2 nibbles merged -> all outputs at reset values immediately, no write after release.

Source files
------------

// File: rtl/boxhead_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boxhead_mem_pkg
//  Description : Shared types and constants for the packed 4-bit pixel
//                frame/sprite memory (word = four 4-bit pixels).
//                Contents: address/data widths, writer FSM state enum,
//                pixel record and a word-close helper.
//  Revision    : 1.0  initial release
// ============================================================================
package boxhead_mem_pkg;

  localparam int PIX_ADDR_W   = 20;
  localparam int WORD_ADDR_W  = 18;
  localparam int PIX_W        = 4;
  localparam int WORD_W       = 16;
  localparam int PIX_PER_WORD = 4;
  localparam int NIB_IDX_W    = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_OPEN  = 2'd1,
    ST_FLUSH = 2'd2
  } pw_state_e;

  typedef struct packed {
    logic [PIX_ADDR_W-1:0] addr;
    logic [PIX_W-1:0]      data;
    logic                  last;
  } pixel_t;

  // A word is closed either by its highest nibble or by an explicit flush.
  function automatic logic word_closes(input logic [NIB_IDX_W-1:0] nib,
                                       input logic                 last);
    return last || (nib == NIB_IDX_W'(PIX_PER_WORD - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_pack_writer_nibble_merge.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_merge
//  Description : Combinational merge of one 4-bit pixel into a 16-bit word
//                accumulator and its per-nibble write mask.
//  Ports       : data_i/mask_i  current accumulator word and mask
//                nib_i          target nibble index
//                pix_i          pixel colour
//                data_o/mask_o  merged word and mask
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_merge
  import boxhead_mem_pkg::*;
#(
  parameter bit               TRANSP_EN  = 1'b1,
  parameter logic [PIX_W-1:0] TRANSP_KEY = 4'h0
) (
  input  logic [WORD_W-1:0]       data_i,
  input  logic [PIX_PER_WORD-1:0] mask_i,
  input  logic [NIB_IDX_W-1:0]    nib_i,
  input  logic [PIX_W-1:0]        pix_i,
  output logic [WORD_W-1:0]       data_o,
  output logic [PIX_PER_WORD-1:0] mask_o
);

  // The data nibble is always written; a transparent pixel only leaves the
  // mask bit untouched so it can never reach memory on its own.
  logic transparent;
  assign transparent = TRANSP_EN && (pix_i == TRANSP_KEY);

  for (genvar n = 0; n < PIX_PER_WORD; n++) begin : g_nib
    logic hit;
    assign hit = (nib_i == NIB_IDX_W'(n));
    assign data_o[PIX_W*n +: PIX_W] = hit ? pix_i : data_i[PIX_W*n +: PIX_W];
    assign mask_o[n] = mask_i[n] | (hit & ~transparent);
  end

endmodule
`default_nettype wire

// File: rtl/pixel_pack_writer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_pack_writer
//  Description : Packs a stream of addressed 4-bit pixels into 16-bit words
//                and issues nibble-masked writes to the frame-buffer memory.
//                Pixels equal to the transparent key never set a mask bit.
//  Ports       : clk, reset            clock / async active-high reset
//                pix_valid/ready/addr/data/last   pixel input stream
//                wr_valid/ready/addr/data/mask    memory write port
//                busy                  open word, pending write or held pixel
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_pack_writer
  import boxhead_mem_pkg::*;
#(
  parameter bit               TRANSP_EN  = 1'b1,
  parameter logic [PIX_W-1:0] TRANSP_KEY = 4'h0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [PIX_ADDR_W-1:0]   pix_addr,
  input  logic [PIX_W-1:0]        pix_data,
  input  logic                    pix_last,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [WORD_ADDR_W-1:0]  wr_addr,
  output logic [WORD_W-1:0]       wr_data,
  output logic [PIX_PER_WORD-1:0] wr_mask,
  output logic                    busy
);

  pw_state_e                state_q, state_d;
  logic [WORD_ADDR_W-1:0]   acc_addr_q, acc_addr_d;
  logic [WORD_W-1:0]        acc_data_q, acc_data_d;
  logic [PIX_PER_WORD-1:0]  acc_mask_q, acc_mask_d;
  pixel_t                   hold_q, hold_d;
  logic                     hold_v_q, hold_v_d;
  logic                     wr_valid_q, wr_valid_d;

  logic                     accept;
  logic                     same_word;
  logic                     flush_done;
  logic [WORD_W-1:0]        base_data;
  logic [PIX_PER_WORD-1:0]  base_mask;
  logic [WORD_W-1:0]        in_merge_data, hold_merge_data;
  logic [PIX_PER_WORD-1:0]  in_merge_mask, hold_merge_mask;

  // Ready is a pure function of state: no path from pix_* or wr_ready.
  assign pix_ready = (state_q != ST_FLUSH);
  assign accept    = pix_valid && pix_ready;
  assign same_word = (pix_addr[PIX_ADDR_W-1:NIB_IDX_W] == acc_addr_q);

  // A fresh word starts from an empty accumulator.
  assign base_data = (state_q == ST_OPEN) ? acc_data_q : '0;
  assign base_mask = (state_q == ST_OPEN) ? acc_mask_q : '0;

  // An all-transparent word has nothing to write, so it leaves FLUSH at once.
  assign flush_done = (acc_mask_q == '0) || (wr_valid_q && wr_ready);

  nibble_merge #(
    .TRANSP_EN  (TRANSP_EN),
    .TRANSP_KEY (TRANSP_KEY)
  ) u_merge_in (
    .data_i (base_data),
    .mask_i (base_mask),
    .nib_i  (pix_addr[NIB_IDX_W-1:0]),
    .pix_i  (pix_data),
    .data_o (in_merge_data),
    .mask_o (in_merge_mask)
  );

  nibble_merge #(
    .TRANSP_EN  (TRANSP_EN),
    .TRANSP_KEY (TRANSP_KEY)
  ) u_merge_hold (
    .data_i ({WORD_W{1'b0}}),
    .mask_i ({PIX_PER_WORD{1'b0}}),
    .nib_i  (hold_q.addr[NIB_IDX_W-1:0]),
    .pix_i  (hold_q.data),
    .data_o (hold_merge_data),
    .mask_o (hold_merge_mask)
  );

  always_comb begin
    state_d    = state_q;
    acc_addr_d = acc_addr_q;
    acc_data_d = acc_data_q;
    acc_mask_d = acc_mask_q;
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          acc_addr_d = pix_addr[PIX_ADDR_W-1:NIB_IDX_W];
          acc_data_d = in_merge_data;
          acc_mask_d = in_merge_mask;
          state_d    = word_closes(pix_addr[NIB_IDX_W-1:0], pix_last) ?
                       ST_FLUSH : ST_OPEN;
        end
      end

      ST_OPEN: begin
        if (accept) begin
          if (same_word) begin
            acc_data_d = in_merge_data;
            acc_mask_d = in_merge_mask;
            state_d    = word_closes(pix_addr[NIB_IDX_W-1:0], pix_last) ?
                         ST_FLUSH : ST_OPEN;
          end else begin
            // Pixel belongs to the next word: park it while this one drains.
            hold_d.addr = pix_addr;
            hold_d.data = pix_data;
            hold_d.last = pix_last;
            hold_v_d    = 1'b1;
            state_d     = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        if (flush_done) begin
          if (hold_v_q) begin
            acc_addr_d = hold_q.addr[PIX_ADDR_W-1:NIB_IDX_W];
            acc_data_d = hold_merge_data;
            acc_mask_d = hold_merge_mask;
            hold_v_d   = 1'b0;
            state_d    = word_closes(hold_q.addr[NIB_IDX_W-1:0], hold_q.last) ?
                         ST_FLUSH : ST_OPEN;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end

      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // The write request is raised exactly when a non-empty word sits in FLUSH
    // next cycle; the accumulator doubles as the write data register.
    wr_valid_d = (state_d == ST_FLUSH) && (acc_mask_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      acc_addr_q <= '0;
      acc_data_q <= '0;
      acc_mask_q <= '0;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_addr_q <= acc_addr_d;
      acc_data_q <= acc_data_d;
      acc_mask_q <= acc_mask_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      wr_valid_q <= wr_valid_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = acc_addr_q;
  assign wr_data  = acc_data_q;
  assign wr_mask  = acc_mask_q;
  assign busy     = (state_q != ST_EMPTY) || hold_v_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_pack_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_pack_writer
//  Description : Scoreboard bench for pixel_pack_writer. Directed pixel
//                sequences push expected writes; a monitor pops and compares
//                on every write handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_pack_writer;

  logic        clk;
  logic        reset;
  logic        pix_valid;
  logic        pix_ready;
  logic [19:0] pix_addr;
  logic [3:0]  pix_data;
  logic        pix_last;
  logic        wr_valid;
  logic        wr_ready;
  logic [17:0] wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  wr_mask;
  logic        busy;

  pixel_pack_writer #(
    .TRANSP_EN  (1'b1),
    .TRANSP_KEY (4'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .pix_last  (pix_last),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
    logic [3:0]  m;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  hs_cnt = 0;
  int  wv_cnt = 0;
  int  ready_low_cnt = 0;
  int  hs_base = 0;

  // Monitor: counts activity and checks every write against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (!pix_ready) ready_low_cnt++;
      if (wr_valid) wv_cnt++;
      if (wr_valid && wr_ready) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%h data=%h mask=%h, required no write",
                   wr_addr, wr_data, wr_mask);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (wr_addr !== e.a || wr_data !== e.d || wr_mask !== e.m) begin
            errors++;
            $display("FAIL wr_word: got addr=%h data=%h mask=%h, required addr=%h data=%h mask=%h",
                     wr_addr, wr_data, wr_mask, e.a, e.d, e.m);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [17:0] a, input logic [15:0] d, input logic [3:0] m);
    wr_t e;
    e.a = a; e.d = d; e.m = m;
    exp_q.push_back(e);
  endtask

  // Starts at #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_pix(input logic [19:0] a, input logic [3:0] d, input logic l);
    int t;
    t = 0;
    pix_valid = 1'b1; pix_addr = a; pix_data = d; pix_last = l;
    @(negedge clk);
    while (!pix_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got pix_ready=0 for %0d cycles, required 1", t);
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0; pix_last = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || wr_valid) && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=%b wr_valid=%b, required 0 0", busy, wr_valid);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    ready_low_cnt = 0;
    wv_cnt = 0;
    hs_base = hs_cnt;
  endtask

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pix_addr = '0; pix_data = '0;
    pix_last = 1'b0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_ready", 32'(pix_ready), 32'd1);
    chk("rst_wr_valid",  32'(wr_valid),  32'd0);
    chk("rst_wr_addr",   32'(wr_addr),   32'd0);
    chk("rst_wr_data",   32'(wr_data),   32'd0);
    chk("rst_wr_mask",   32'(wr_mask),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // Full contiguous word.
    start_test();
    push_exp(18'h00004, 16'h4321, 4'hF);
    send_pix(20'h00010, 4'h1, 1'b0);
    send_pix(20'h00011, 4'h2, 1'b0);
    send_pix(20'h00012, 4'h3, 1'b0);
    send_pix(20'h00013, 4'h4, 1'b0);
    wait_idle();
    chk("full_ready_low", 32'(ready_low_cnt), 32'd1);
    chk("full_writes",    32'(hs_cnt - hs_base), 32'd1);

    // Transparent key in the middle, flushed by last.
    start_test();
    push_exp(18'h00008, 16'h0705, 4'b0101);
    send_pix(20'h00020, 4'h5, 1'b0);
    send_pix(20'h00021, 4'h0, 1'b0);
    send_pix(20'h00022, 4'h7, 1'b1);
    wait_idle();
    chk("transp_writes", 32'(hs_cnt - hs_base), 32'd1);

    // Word change: first pixel held, both words written.
    start_test();
    push_exp(18'h00000, 16'h00A0, 4'b0010);
    push_exp(18'h00002, 16'h00B0, 4'b0010);
    send_pix(20'h00001, 4'hA, 1'b0);
    send_pix(20'h00009, 4'hB, 1'b1);
    wait_idle();
    chk("hold_writes",    32'(hs_cnt - hs_base), 32'd2);
    chk("hold_ready_low", 32'(ready_low_cnt), 32'd2);

    // Fully transparent word: no write request at all.
    start_test();
    send_pix(20'h00014, 4'h0, 1'b0);
    send_pix(20'h00015, 4'h0, 1'b0);
    send_pix(20'h00016, 4'h0, 1'b0);
    send_pix(20'h00017, 4'h0, 1'b1);
    wait_idle();
    chk("allkey_wr_valid",  32'(wv_cnt), 32'd0);
    chk("allkey_ready_low", 32'(ready_low_cnt), 32'd1);
    chk("allkey_busy",      32'(busy), 32'd0);

    // Repeated nibble: later transparent pixel overwrites data, mask stays.
    start_test();
    push_exp(18'h00010, 16'h0000, 4'b0001);
    send_pix(20'h00040, 4'h3, 1'b0);
    send_pix(20'h00040, 4'h0, 1'b0);
    send_pix(20'h00041, 4'h0, 1'b1);
    wait_idle();
    chk("repeat_writes", 32'(hs_cnt - hs_base), 32'd1);

    // Back-pressure: write stalled for 10 cycles.
    start_test();
    wr_ready = 1'b0;
    push_exp(18'h00004, 16'h6789, 4'hF);
    send_pix(20'h00010, 4'h9, 1'b0);
    send_pix(20'h00011, 4'h8, 1'b0);
    send_pix(20'h00012, 4'h7, 1'b0);
    send_pix(20'h00013, 4'h6, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_state", {pix_ready, wr_valid, wr_mask, wr_addr[9:0], wr_data},
          {1'b0, 1'b1, 4'hF, 10'h004, 16'h6789});
    end
    @(posedge clk);
    #1;
    wr_ready = 1'b1;
    wait_idle();
    chk("stall_writes", 32'(hs_cnt - hs_base), 32'd1);

    // Reset while a word is half-assembled.
    start_test();
    send_pix(20'h00030, 4'h1, 1'b0);
    send_pix(20'h00031, 4'h2, 1'b0);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_pix_ready", 32'(pix_ready), 32'd1);
    chk("mid_rst_wr_valid",  32'(wr_valid),  32'd0);
    chk("mid_rst_wr_word",   {14'd0, wr_addr} | 32'(wr_data) | 32'(wr_mask), 32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_writes", 32'(hs_cnt - hs_base), 32'd0);
    chk("post_rst_wr_valid", 32'(wv_cnt), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
